// File: rtl/alu_issue_ctrl.sv
// Register-to-register issue/writeback sequencer for the 4-bit combinational ALU.
// Handles one instruction at a time: operand fetch, ALU drive, capture/writeback, then a held response.
module alu_issue_ctrl #(
    parameter int DATA_W = 4,
    parameter int OPC_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [1:0]        in_dst,
    input  logic [1:0]        in_src_a,
    input  logic [1:0]        in_src_b,
    input  logic              ld_en,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_dst,
    output logic [DATA_W-1:0] out_result,
    output logic              out_overflow,
    input  logic              clr_sticky,
    output logic              ovf_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_overflow_r;
    logic              ovf_sticky_r;
    logic [OPC_W-1:0]  alu_opcode_r;
    logic [DATA_W-1:0] alu_operand_a_r;
    logic [DATA_W-1:0] alu_operand_b_r;
    logic [DATA_W-1:0] out_result_r;
    logic [1:0]        dst_r;
    logic [1:0]        out_dst_r;
    logic [DATA_W-1:0] rf_r [4];
    logic              wb_en_s;

    // The ALU result is valid only while its inputs have been stable for the EXEC cycle.
    assign wb_en_s = (state_r == EXEC);

    // Instruction sequencer with registered handshake flags and ALU/response drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            in_ready_r      <= 1'b1;
            out_valid_r     <= 1'b0;
            alu_opcode_r    <= {OPC_W{1'b0}};
            alu_operand_a_r <= {DATA_W{1'b0}};
            alu_operand_b_r <= {DATA_W{1'b0}};
            dst_r           <= 2'd0;
            out_dst_r       <= 2'd0;
            out_result_r    <= {DATA_W{1'b0}};
            out_overflow_r  <= 1'b0;
            ovf_sticky_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        alu_opcode_r    <= in_opcode;
                        alu_operand_a_r <= rf_r[in_src_a];
                        alu_operand_b_r <= rf_r[in_src_b];
                        dst_r           <= in_dst;
                        in_ready_r      <= 1'b0;
                        state_r         <= EXEC;
                    end
                end
                EXEC: begin
                    out_result_r   <= alu_result;
                    out_overflow_r <= alu_overflow;
                    out_dst_r      <= dst_r;
                    out_valid_r    <= 1'b1;
                    state_r        <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
            // A capture-edge overflow must survive a simultaneous clear.
            if (wb_en_s && alu_overflow) begin
                ovf_sticky_r <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky_r <= 1'b0;
            end
        end
    end

    // Register file: EXEC writeback overrides a preload aimed at the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wb_en_s && (dst_r == i[1:0])) begin
                    rf_r[i] <= alu_result;
                end else if (ld_en && (ld_addr == i[1:0])) begin
                    rf_r[i] <= ld_data;
                end
            end
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign alu_opcode    = alu_opcode_r;
    assign alu_operand_a = alu_operand_a_r;
    assign alu_operand_b = alu_operand_b_r;
    assign out_dst       = out_dst_r;
    assign out_result    = out_result_r;
    assign out_overflow  = out_overflow_r;
    assign ovf_sticky    = ovf_sticky_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a small behavioural ALU drives the result path,
// and a register-file/sticky reference model supplies every expected value.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [1:0] in_dst;
    logic [1:0] in_src_a;
    logic [1:0] in_src_b;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [2:0] alu_opcode;
    logic [3:0] alu_operand_a;
    logic [3:0] alu_operand_b;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_dst;
    logic [3:0] out_result;
    logic       out_overflow;
    logic       clr_sticky;
    logic       ovf_sticky;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference state: architectural register contents and sticky flag.
    logic [3:0] m_rf [4];
    logic       m_sticky;
    logic [3:0] exp_a, exp_b, exp_res;
    logic       exp_ovf, exp_sticky;

    // Observations captured by the driver.
    logic [2:0] obs_op;
    logic [3:0] obs_a, obs_b, obs_res;
    logic       obs_ovf, obs_sticky, obs_v_exec, obs_rdy_exec, obs_v_resp, obs_rdy_after, obs_v_after;
    logic [1:0] obs_dst;
    logic       obs_unstable;
    int         obs_acc_cyc;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst),
        .out_result(out_result), .out_overflow(out_overflow),
        .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
    );

    // Bench ALU: even opcodes add, odd opcodes subtract, 4-bit with signed overflow.
    function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] s;
        logic       v;
        if (op[0] == 1'b0) begin
            s = a + b;
            v = (a[3] == b[3]) && (s[3] != a[3]);
        end else begin
            s = a - b;
            v = (a[3] != b[3]) && (s[3] != a[3]);
        end
        return {v, s};
    endfunction

    assign {alu_overflow, alu_result} = alu_ref(alu_opcode, alu_operand_a, alu_operand_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic preload(input logic [1:0] a, input logic [3:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        m_rf[a] = d;
    endtask

    task automatic pulse_clr();
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        m_sticky = 1'b0;
    endtask

    // Reference: operands read before any same-instruction load; writeback beats a load to dst.
    task automatic model_step(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                              input logic [1:0] sb, input bit clr, input bit ld,
                              input logic [1:0] la, input logic [3:0] ldd);
        exp_a = m_rf[sa];
        exp_b = m_rf[sb];
        {exp_ovf, exp_res} = alu_ref(op, exp_a, exp_b);
        if (ld) m_rf[la] = ldd;
        m_rf[dst] = exp_res;
        if (exp_ovf) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        exp_sticky = m_sticky;
    endtask

    // Drives one instruction from IDLE through the response handshake; ld_mode 1 = load on accept edge, 2 = on capture edge.
    task automatic do_issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                            input logic [1:0] sb, input int stall, input bit clr_cap, input int ld_mode,
                            input logic [1:0] la, input logic [3:0] ldd, input bit keep_valid);
        in_valid = 1'b1; in_opcode = op; in_dst = dst; in_src_a = sa; in_src_b = sb;
        ld_addr = la; ld_data = ldd; ld_en = (ld_mode == 1);
        @(posedge clk); #1;
        obs_acc_cyc = cyc;
        obs_op = alu_opcode; obs_a = alu_operand_a; obs_b = alu_operand_b;
        obs_v_exec = out_valid; obs_rdy_exec = in_ready;
        if (keep_valid) in_opcode = op + 3'd1;
        else in_valid = 1'b0;
        ld_en = (ld_mode == 2); clr_sticky = clr_cap;
        @(posedge clk); #1;
        ld_en = 1'b0; clr_sticky = 1'b0;
        obs_v_resp = out_valid; obs_res = out_result; obs_ovf = out_overflow;
        obs_dst = out_dst; obs_sticky = ovf_sticky;
        obs_unstable = (in_ready !== 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_result !== obs_res || out_overflow !== obs_ovf ||
                out_dst !== obs_dst || in_ready !== 1'b0 || alu_opcode !== obs_op)
                obs_unstable = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        obs_rdy_after = in_ready; obs_v_after = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 3'd0; in_dst = 2'd0; in_src_a = 2'd0; in_src_b = 2'd0;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'd0; out_ready = 1'b0; clr_sticky = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        m_sticky = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({alu_opcode, alu_operand_a, alu_operand_b} !== 11'd0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {alu_opcode, alu_operand_a, alu_operand_b}); end
        checks++; if ({out_dst, out_result, out_overflow, ovf_sticky} !== 8'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", {out_dst, out_result, out_overflow, ovf_sticky}); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_add();
        preload(2'd0, 4'd8);
        preload(2'd1, 4'd7);
        model_step(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd2, 2'd0, 2'd1, 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_a !== 4'd8 || obs_b !== 4'd7) begin failures++; $display("FAIL add_operands got=%0d,%0d exp=8,7", obs_a, obs_b); end
        checks++; if (obs_v_exec !== 1'b0 || obs_v_resp !== 1'b1) begin failures++; $display("FAIL add_valid_timing got=%b%b exp=01", obs_v_exec, obs_v_resp); end
        checks++; if (obs_res !== 4'hF || obs_ovf !== 1'b0 || obs_dst !== 2'd2) begin failures++; $display("FAIL add_result got=%h/%b/%0d exp=f/0/2", obs_res, obs_ovf, obs_dst); end
        checks++; if (obs_rdy_after !== 1'b1 || obs_v_after !== 1'b0) begin failures++; $display("FAIL add_return_idle got=%b%b exp=10", obs_rdy_after, obs_v_after); end
        model_step(3'd0, 2'd3, 2'd2, 2'd3, 1'b0, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd3, 2'd2, 2'd3, 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_a !== 4'd15) begin failures++; $display("FAIL add_writeback_r2 got=%0d exp=15", obs_a); end
    endtask

    task automatic test_overflow_sticky();
        preload(2'd0, 4'd7);
        preload(2'd1, 4'd1);
        model_step(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd2, 2'd0, 2'd1, 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_res !== 4'd8 || obs_ovf !== 1'b1 || obs_sticky !== 1'b1) begin failures++; $display("FAIL ovf_capture got=%0d/%b/%b exp=8/1/1", obs_res, obs_ovf, obs_sticky); end
        model_step(3'd0, 2'd3, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd3, 2'd1, 2'd1, 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_ovf !== 1'b0 || obs_sticky !== 1'b1) begin failures++; $display("FAIL ovf_sticky_hold got=%b/%b exp=0/1", obs_ovf, obs_sticky); end
        pulse_clr();
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL ovf_sticky_clear got=%b exp=0", ovf_sticky); end
        model_step(3'd0, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd2, 2'd0, 2'd1, 0, 1'b1, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_sticky !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clear got=%b exp=1", obs_sticky); end
        model_step(3'd0, 2'd3, 2'd1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd3, 2'd1, 2'd1, 0, 1'b1, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_sticky !== 1'b0) begin failures++; $display("FAIL ovf_clear_on_capture got=%b exp=0", obs_sticky); end
    endtask

    task automatic test_backpressure();
        model_step(3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);
        do_issue(3'd1, 2'd2, 2'd0, 2'd1, 5, 1'b0, 0, 2'd0, 4'd0, 1'b1);
        checks++; if (obs_unstable !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b exp=0", obs_unstable); end
        checks++; if (obs_res !== exp_res || obs_v_resp !== 1'b1) begin failures++; $display("FAIL bp_result got=%0d/%b exp=%0d/1", obs_res, obs_v_resp, exp_res); end
        checks++; if (obs_rdy_after !== 1'b1 || obs_v_after !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b exp=10", obs_rdy_after, obs_v_after); end
    endtask

    task automatic test_collision();
        preload(2'd0, 4'd3);
        preload(2'd1, 4'd2);
        model_step(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 2'd2, 4'd3);
        do_issue(3'd0, 2'd2, 2'd0, 2'd1, 0, 1'b0, 2, 2'd2, 4'd3, 1'b0);
        model_step(3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd0, 2'd2, 2'd2, 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_a !== 4'd5 || obs_b !== 4'd5) begin failures++; $display("FAIL coll_wb_wins got=%0d,%0d exp=5,5", obs_a, obs_b); end
        model_step(3'd0, 2'd3, 2'd0, 2'd1, 1'b0, 1'b1, 2'd1, 4'd9);
        do_issue(3'd0, 2'd3, 2'd0, 2'd1, 0, 1'b0, 2, 2'd1, 4'd9, 1'b0);
        model_step(3'd1, 2'd0, 2'd1, 2'd3, 1'b0, 1'b1, 2'd3, 4'd6);
        do_issue(3'd1, 2'd0, 2'd1, 2'd3, 0, 1'b0, 1, 2'd3, 4'd6, 1'b0);
        checks++; if (obs_a !== exp_a || obs_b !== exp_b) begin failures++; $display("FAIL coll_no_bypass got=%0d,%0d exp=%0d,%0d", obs_a, obs_b, exp_a, exp_b); end
        model_step(3'd0, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);
        do_issue(3'd0, 2'd2, 2'd3, 2'd1, 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
        checks++; if (obs_a !== 4'd6 || obs_b !== 4'd9) begin failures++; $display("FAIL coll_both_loads got=%0d,%0d exp=6,9", obs_a, obs_b); end
    endtask

    task automatic test_reset_mid();
        preload(2'd0, 4'd5);
        preload(2'd1, 4'd6);
        preload(2'd2, 4'd7);
        preload(2'd3, 4'd9);
        in_valid = 1'b1; in_opcode = 3'd2; in_dst = 2'd3; in_src_a = 2'd0; in_src_b = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_handshake got=%b%b exp=10", in_ready, out_valid); end
        checks++; if ({alu_opcode, alu_operand_a, alu_operand_b} !== 11'd0) begin failures++; $display("FAIL rstmid_alu got=%h exp=0", {alu_opcode, alu_operand_a, alu_operand_b}); end
        checks++; if ({out_dst, out_result, out_overflow, ovf_sticky} !== 8'd0) begin failures++; $display("FAIL rstmid_out got=%h exp=0", {out_dst, out_result, out_overflow, ovf_sticky}); end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        m_sticky = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_no_resp got=%b%b exp=01", out_valid, in_ready); end
        for (int i = 0; i < 4; i++) begin
            model_step(3'd0, 2'(i), 2'(i), 2'(i), 1'b0, 1'b0, 2'd0, 4'd0);
            do_issue(3'd0, 2'(i), 2'(i), 2'(i), 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
            checks++; if (obs_a !== 4'd0 || obs_b !== 4'd0) begin failures++; $display("FAIL rstmid_rf%0d got=%0d,%0d exp=0,0", i, obs_a, obs_b); end
        end
    endtask

    task automatic test_sweep();
        int prev;
        prev = 0;
        preload(2'd0, 4'd8);
        preload(2'd1, 4'd7);
        for (int k = 0; k < 8; k++) begin
            model_step(3'(k), 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);
            do_issue(3'(k), 2'd3, 2'd0, 2'd1, 0, 1'b0, 0, 2'd0, 4'd0, 1'b0);
            checks++; if (obs_op !== 3'(k) || obs_res !== exp_res || obs_ovf !== exp_ovf) begin failures++; $display("FAIL sweep_op%0d got=%0d/%0d/%b exp=%0d/%0d/%b", k, obs_op, obs_res, obs_ovf, k, exp_res, exp_ovf); end
            if (k > 0) begin
                checks++; if (obs_acc_cyc - prev != 3) begin failures++; $display("FAIL sweep_spacing%0d got=%0d exp=3", k, obs_acc_cyc - prev); end
            end
            prev = obs_acc_cyc;
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [1:0] dst, sa, sb, la;
        logic [3:0] ldd;
        bit         clr, kv;
        int         stall, ldm;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) preload(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            op = 3'($urandom_range(0, 7)); dst = 2'($urandom_range(0, 3));
            sa = 2'($urandom_range(0, 3)); sb = 2'($urandom_range(0, 3));
            la = 2'($urandom_range(0, 3)); ldd = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 3) == 0); kv = ($urandom_range(0, 1) == 1);
            stall = $urandom_range(0, 2); ldm = $urandom_range(0, 2);
            model_step(op, dst, sa, sb, clr, ldm != 0, la, ldd);
            do_issue(op, dst, sa, sb, stall, clr, ldm, la, ldd, kv);
            checks++; if (obs_op !== op || obs_a !== exp_a || obs_b !== exp_b) begin failures++; $display("FAIL rnd%0d_drive got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, obs_op, obs_a, obs_b, op, exp_a, exp_b); end
            checks++; if (obs_res !== exp_res || obs_ovf !== exp_ovf || obs_dst !== dst) begin failures++; $display("FAIL rnd%0d_resp got=%0d/%b/%0d exp=%0d/%b/%0d", n, obs_res, obs_ovf, obs_dst, exp_res, exp_ovf, dst); end
            checks++; if (obs_sticky !== exp_sticky) begin failures++; $display("FAIL rnd%0d_sticky got=%b exp=%b", n, obs_sticky, exp_sticky); end
            checks++; if ({obs_v_exec, obs_rdy_exec, obs_v_resp, obs_unstable, obs_rdy_after} !== 5'b00101) begin failures++; $display("FAIL rnd%0d_handshake got=%b exp=00101", n, {obs_v_exec, obs_rdy_exec, obs_v_resp, obs_unstable, obs_rdy_after}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_overflow_sticky();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
